// File: rtl/test_unit.sv
// rtl/test_unit.sv - synchronous single-clock FIFO with occupancy flags and protocol-error pulses
module test_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             wr_err,
   output logic             rd_err
);

   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
   logic [AW:0]      count_q,    count_d;
   logic [WIDTH-1:0] rd_data_q,  rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             wr_err_q,   wr_err_d;
   logic             rd_err_q,   rd_err_d;

   logic             full_w;
   logic             empty_w;
   logic             rd_ok;
   logic             wr_ok;

   // Flags decode the registered count so they are valid in the same cycle.
   always_comb begin
      full_w  = (count_q == CNT_FULL);
      empty_w = (count_q == '0);
      // A read frees a slot this cycle, so a full FIFO can still take a write;
      // an empty FIFO never forwards write data straight to the read side.
      rd_ok   = rd_en && !empty_w;
      wr_ok   = wr_en && (!full_w || rd_ok);
   end

   // Next-state for pointers, occupancy, read data and the error/valid pulses.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_err_d   = 1'b0;
      rd_err_d   = 1'b0;

      if (reset) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         rd_data_d = '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         wr_err_d = wr_en && !wr_ok;
         rd_err_d = rd_en && !rd_ok;
      end
   end

   // State register; reset is folded into the next-state logic above.
   always_ff @(posedge clk) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
   end

   // Storage array: no reset, written only on an accepted write outside reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign full     = full_w;
   assign empty    = empty_w;
   assign count    = count_q;
   assign wr_err   = wr_err_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_test_unit.sv
// tb/tb_test_unit.sv - self-checking bench for test_unit against a queue-based FIFO model
module tb_test_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             wr_err;
   logic             rd_err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a plain queue plus the expected registered outputs.
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] exp_rd_data  = '0;
   logic             exp_rd_valid = 1'b0;
   logic             exp_wr_err   = 1'b0;
   logic             exp_rd_err   = 1'b0;

   test_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .wr_err   (wr_err),
      .rd_err   (rd_err)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] obs_vec();
      return {rd_data, rd_valid, full, empty, count, wr_err, rd_err};
   endfunction

   function automatic logic [16:0] exp_vec();
      int n = model_q.size();
      return {exp_rd_data, exp_rd_valid, (n == DEPTH), (n == 0), 4'(n), exp_wr_err, exp_rd_err};
   endfunction

   // One clock edge with the given requests; model follows the FIFO rules.
   task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re);
      bit can_rd, can_wr;
      wr_en = we; wr_data = wd; rd_en = re;
      @(posedge clk);
      #1;
      can_rd = re && (model_q.size() > 0);
      can_wr = we && ((model_q.size() < DEPTH) || can_rd);
      exp_rd_valid = can_rd;
      exp_wr_err   = we && !can_wr;
      exp_rd_err   = re && !can_rd;
      if (can_rd) exp_rd_data = model_q.pop_front();
      if (can_wr) model_q.push_back(wd);
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // Reset with random requests asserted to exercise reset priority.
   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'($urandom); rd_en = 1'($urandom); wr_data = 8'($urandom);
      @(posedge clk);
      #1;
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_q.delete();
      exp_rd_data = '0; exp_rd_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cycle(1'b0, '0, 1'b0);
      n_vec++;
      if ({empty, full, count, rd_valid, rd_data} !== {1'b1, 1'b0, 4'd0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_state got e=%b f=%b c=%0d v=%b d=%h exp e=1 f=0 c=0 v=0 d=00",
                  empty, full, count, rd_valid, rd_data);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
      n_vec++;
      if ({full, count} !== {1'b1, 4'd8}) begin
         n_err++;
         $display("FAIL fill got full=%b count=%0d exp full=1 count=8", full, count);
      end
      cycle(1'b1, 8'h99, 1'b0);
      n_vec++;
      if ({wr_err, count} !== {1'b1, 4'd8}) begin
         n_err++;
         $display("FAIL overflow got wr_err=%b count=%0d exp wr_err=1 count=8", wr_err, count);
      end
      cycle(1'b0, '0, 1'b0);
      n_vec++;
      if (wr_err !== 1'b0) begin
         n_err++;
         $display("FAIL wr_err_pulse got %b exp 0", wr_err);
      end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, '0, 1'b1);
         n_vec++;
         if ({rd_valid, rd_data} !== {1'b1, 8'(8'h11 + i)}) begin
            n_err++;
            $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'(8'h11 + i));
         end
      end
      n_vec++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL drained_empty got %b exp 1", empty);
      end
      cycle(1'b0, '0, 1'b1);
      n_vec++;
      if ({rd_err, rd_valid, rd_data} !== {1'b1, 1'b0, 8'h18}) begin
         n_err++;
         $display("FAIL underflow got rd_err=%b v=%b d=%h exp rd_err=1 v=0 d=18", rd_err, rd_valid, rd_data);
      end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0);
      cycle(1'b1, 8'hAA, 1'b1);
      n_vec++;
      if ({rd_data, count, wr_err, rd_valid} !== {8'h11, 4'd8, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL full_rw got d=%h c=%0d wr_err=%b v=%b exp d=11 c=8 wr_err=0 v=1",
                  rd_data, count, wr_err, rd_valid);
      end
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
      n_vec++;
      if ({rd_data, empty} !== {8'hAA, 1'b1}) begin
         n_err++;
         $display("FAIL full_rw_last got d=%h empty=%b exp d=aa empty=1", rd_data, empty);
      end
   endtask

   task automatic test_empty_simul();
      do_reset();
      cycle(1'b1, 8'h5C, 1'b1);
      n_vec++;
      if ({rd_err, count, wr_err, rd_valid} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL empty_rw got rd_err=%b c=%0d wr_err=%b v=%b exp rd_err=1 c=1 wr_err=0 v=0",
                  rd_err, count, wr_err, rd_valid);
      end
      cycle(1'b0, '0, 1'b1);
      n_vec++;
      if ({rd_data, rd_valid} !== {8'h5C, 1'b1}) begin
         n_err++;
         $display("FAIL empty_rw_read got d=%h v=%b exp d=5c v=1", rd_data, rd_valid);
      end
   endtask

   task automatic test_wrap();
      int lens[4] = '{5, 5, 6, 6};
      do_reset();
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < lens[p]; i++) begin
            cycle(p % 2 == 0, 8'($urandom), p % 2 == 1);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
               n_err++;
               $display("FAIL wrap[%0d.%0d] got %h exp %h", p, i, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0);
      n_vec++;
      if (count !== 4'd3) begin
         n_err++;
         $display("FAIL mid_count got %0d exp 3", count);
      end
      do_reset();
      n_vec++;
      if ({count, empty, full, rd_data} !== {4'd0, 1'b1, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL mid_reset got c=%0d e=%b f=%b d=%h exp c=0 e=1 f=0 d=00", count, empty, full, rd_data);
      end
   endtask

   task automatic test_random();
      int wr_bias;
      for (int i = 0; i < 600; i++) begin
         wr_bias = ((i / 50) % 2 == 0) ? 75 : 25;
         if ($urandom_range(99) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(99) < wr_bias, 8'($urandom), $urandom_range(99) >= wr_bias - 10);
         end
         n_vec++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL random[%0d] got %h exp %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_full_simul();
      test_empty_simul();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
